// File: rtl/pmem_arbiter_if.sv
// Bundle of client request/response and physical-memory signals for pmem_arbiter.
// master is the arbiter's view; slave is the view of the surrounding clients and memory.
interface pmem_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic [NUM_PORTS-1:0]            req_read;
    logic [NUM_PORTS-1:0]            req_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
    logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            req_resp;
    logic [LINE_WIDTH-1:0]           req_rdata;
    logic                            pmem_resp;
    logic                            pmem_read;
    logic                            pmem_write;
    logic [ADDR_WIDTH-1:0]           pmem_address;
    logic [LINE_WIDTH-1:0]           pmem_rdata;
    logic [LINE_WIDTH-1:0]           pmem_wdata;

    modport master (
        input  req_read, req_write, req_address, req_wdata, pmem_resp, pmem_rdata,
        output req_resp, req_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        output req_read, req_write, req_address, req_wdata, pmem_resp, pmem_rdata,
        input  req_resp, req_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// N-channel line arbiter in front of a single physical-memory port, one transaction at a time.
// Round-robin by default; define PMEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module pmem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input logic           clk,
    input logic           rst,
    pmem_arbiter_if.master bus
);
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_reg, state_next;
    logic [GW-1:0]         grant_reg, grant_next;
    logic                  op_write_reg, op_write_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [LINE_WIDTH-1:0] wdata_reg, wdata_next;
    logic [LINE_WIDTH-1:0] rdata_reg, rdata_next;

    logic [NUM_PORTS-1:0]  active;
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
    logic [LINE_WIDTH-1:0] wdata_arr [NUM_PORTS];
    logic [GW-1:0]         win;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign active[gi]    = bus.req_read[gi] | bus.req_write[gi];
            assign addr_arr[gi]  = bus.req_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = bus.req_wdata[gi*LINE_WIDTH +: LINE_WIDTH];
            assign bus.req_resp[gi] = (state_reg == RESP) && (grant_reg == GW'(gi));
        end
    endgenerate

`ifdef PMEM_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest active index is the last one written.
    always_comb begin
        win = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (active[GW'(i)]) win = GW'(i);
        end
    end
`else
    logic [GW-1:0] last_grant_reg, last_grant_next;

    // Scan from last_grant+1 upward; descending k leaves the nearest candidate in win.
    always_comb begin
        logic [GW-1:0] idx;
        win = '0;
        idx = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = GW'((int'(last_grant_reg) + k) % NUM_PORTS);
            if (active[idx]) win = idx;
        end
    end

    assign last_grant_next = (state_reg == RESP) ? grant_reg : last_grant_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant_reg <= GW'(NUM_PORTS - 1);
        else     last_grant_reg <= last_grant_next;
    end
`endif

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        op_write_next = op_write_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (|active) begin
                    grant_next    = win;
                    op_write_next = bus.req_write[win];
                    addr_next     = addr_arr[win];
                    wdata_next    = wdata_arr[win];
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                if (bus.pmem_resp) begin
                    if (!op_write_reg) rdata_next = bus.pmem_rdata;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            op_write_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            op_write_reg <= op_write_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
        end
    end

    // Strobes decode from state so an asynchronous reset drops them at once.
    assign bus.pmem_read    = (state_reg == BUSY) && !op_write_reg;
    assign bus.pmem_write   = (state_reg == BUSY) &&  op_write_reg;
    assign bus.pmem_address = addr_reg;
    assign bus.pmem_wdata   = wdata_reg;
    assign bus.req_rdata    = rdata_reg;
endmodule
